nihilist_encrypt_stream: RTL and testbench

- Streaming Nihilist-cipher encryptor; the transmit-side counterpart of the existing combinational decrypt block.
- Accepts plaintext characters one per handshake and emits one cipher byte per character.
- Cipher byte = Polybius code of plaintext + Polybius code of key[i % SEC_LEN], where code = row*10 + col.
- Uses the same 5x5 square (MATEI/BCDFG/HKLNO/PQRSU/VWXYZ) and the same key PARASCHIV, so its output is decryptable by the decrypt block.

---
 rtl/nihilist_pkg.sv | 30 +++
 rtl/nihilist_encrypt_stream_polybius_lookup.sv | 27 ++
 rtl/nihilist_encrypt_stream.sv | 102 ++++++++++
 tb/tb_nihilist_encrypt_stream.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/nihilist_pkg.sv
// Shared constants for the Nihilist cipher blocks: the Polybius square,
// the key and its precomputed codes, and the stream FSM state type.
package nihilist_pkg;

  localparam int SQ_N    = 25;
  localparam int KEY_LEN = 9;

  // Row-major 5x5 square; index 0 is the top-left cell.
  localparam logic [0:SQ_N-1][7:0] SQUARE = "MATEIBCDFGHKLNOPQRSUVWXYZ";

  localparam logic [0:KEY_LEN-1][7:0] KEY = "PARASCHIV";

  // Polybius codes of KEY, so the key path needs no lookup.
  localparam logic [0:KEY_LEN-1][7:0] KEY_CODES = {
    8'd41, 8'd12, 8'd43, 8'd12, 8'd44, 8'd22, 8'd31, 8'd15, 8'd51
  };

  localparam logic [7:0] INVALID_CODE = 8'h00;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // Code of the cell at a given square index: (row+1)*10 + (col+1).
  function automatic logic [7:0] square_code(input int idx);
    return 8'((idx / 5 + 1) * 10 + (idx % 5) + 1);
  endfunction

endpackage

// File: rtl/nihilist_encrypt_stream_polybius_lookup.sv
// Combinational Polybius lookup with case folding (a-z -> A-Z, J -> I).
module polybius_lookup
  import nihilist_pkg::*;
(
  input  logic [7:0] char,
  output logic [7:0] code,
  output logic       valid
);

  logic [7:0] folded;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    folded = char;
    code   = INVALID_CODE;
    valid  = 1'b0;
    if (char >= "a" && char <= "z") folded = char - 8'd32;
    if (folded == "J") folded = "I";
    for (int i = 0; i < SQ_N; i++) begin
      if (SQUARE[i] == folded) begin
        code  = square_code(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nihilist_encrypt_stream.sv
// Streaming Nihilist encryptor: two-stage pipeline, one cipher byte per
// plaintext character, key position carried across the whole message.
module nihilist_encrypt_stream
  import nihilist_pkg::*;
#(
  parameter int SEC_LEN = 9,
  parameter int ERR_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_cipher,
  output logic             out_err,
  output logic             out_last,
  output logic [ERR_W-1:0] err_count
);

  localparam int IDX_W = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] key_idx;
  logic             adv, accept;
  logic [7:0]       lk_code;
  logic             lk_valid;

  logic             s1_valid;
  logic [7:0]       s1_ptext, s1_key;
  logic             s1_err, s1_last;

  polybius_lookup u_lookup (
    .char  (in_char),
    .code  (lk_code),
    .valid (lk_valid)
  );

  assign adv      = !out_valid || out_ready;
  assign in_ready = (state_q == ST_RUN) && adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (accept && in_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      key_idx   <= '0;
      err_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        key_idx   <= '0;
        err_count <= '0;
      end else if (accept) begin
        key_idx <= (key_idx == IDX_W'(SEC_LEN - 1)) ? '0 : key_idx + 1'b1;
        if (!lk_valid && err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

  // Both stages advance together; payload only loads behind a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_ptext   <= '0;
      s1_key     <= '0;
      s1_err     <= 1'b0;
      s1_last    <= 1'b0;
      out_valid  <= 1'b0;
      out_cipher <= '0;
      out_err    <= 1'b0;
      out_last   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= accept;
      out_valid <= s1_valid;
      if (accept) begin
        s1_ptext <= lk_code;
        s1_key   <= KEY_CODES[key_idx];
        s1_err   <= !lk_valid;
        s1_last  <= in_last;
      end
      if (s1_valid) begin
        out_cipher <= s1_err ? INVALID_CODE : s1_ptext + s1_key;
        out_err    <= s1_err;
        out_last   <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_nihilist_encrypt_stream.sv
// Directed bench for nihilist_encrypt_stream with hand-computed cipher values.
module tb_nihilist_encrypt_stream;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_last, out_ready;
  logic [7:0] in_char;
  logic       in_ready, out_valid, out_err, out_last;
  logic [7:0] out_cipher;
  logic [1:0] err_count;

  typedef struct packed {
    logic [7:0] c;
    logic       e;
    logic       l;
  } beat_t;

  beat_t      out_q[$];
  logic [7:0] exp_c[$];
  logic       exp_e[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc_cyc, first_acc_cyc, last_rise_cyc;

  nihilist_encrypt_stream #(.SEC_LEN(9), .ERR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cipher (out_cipher),
    .out_err    (out_err),
    .out_last   (out_last),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Collect transferred beats and verify outputs hold while stalled.
  logic  held = 1'b0;
  logic  prev_valid = 1'b0;
  beat_t prev_beat;
  always @(negedge clk) begin
    if (rst) begin
      held       = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_cipher", out_cipher, prev_beat.c);
        check("hold_err", out_err, prev_beat.e);
        check("hold_last", out_last, prev_beat.l);
      end
      if (out_valid && !prev_valid) last_rise_cyc = cyc;
      if (out_valid && out_ready) out_q.push_back({out_cipher, out_err, out_last});
      held       = out_valid && !out_ready;
      prev_beat  = {out_cipher, out_err, out_last};
      prev_valid = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] c, input logic last, input bit toggle);
    bit accepted = 0;
    int budget   = 0;
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    while (!accepted && budget < 50) begin
      @(negedge clk);
      if (in_ready) begin
        accepted     = 1;
        last_acc_cyc = cyc;
      end
      step();
      if (toggle) out_ready = ~out_ready;
      budget++;
    end
    check("beat_accepted", accepted, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_at_end, input bit toggle);
    for (int i = 0; i < s.len(); i++)
      send_beat(s[i], last_at_end && (i == s.len() - 1), toggle);
  endtask

  task automatic drain(input int n, input bit toggle);
    int budget = 0;
    while (out_q.size() < n && budget < 100) begin
      step();
      if (toggle) out_ready = ~out_ready;
      budget++;
    end
    out_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic compare_msg(input string tag);
    check({tag, "_count"}, out_q.size(), exp_c.size());
    for (int i = 0; i < exp_c.size() && i < out_q.size(); i++) begin
      check($sformatf("%s_cipher%0d", tag, i), out_q[i].c, exp_c[i]);
      check($sformatf("%s_err%0d", tag, i), out_q[i].e, exp_e[i]);
      check($sformatf("%s_last%0d", tag, i), out_q[i].l, (i == exp_c.size() - 1));
    end
    out_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_char = 8'h00; out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_cipher", out_cipher, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err_count", err_count, 0);

    // HELLO with continuous out_ready.
    pulse_start();
    check("run_in_ready", in_ready, 1);
    send_beat("H", 1'b0, 1'b0);
    first_acc_cyc = last_acc_cyc;
    send_str("ELLO", 1'b1, 1'b0);
    check("hello_idle_after_last", in_ready, 0);
    drain(5, 1'b0);
    check("hello_latency", last_rise_cyc - first_acc_cyc, 2);
    exp_c = {8'd72, 8'd26, 8'd76, 8'd45, 8'd79};
    exp_e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    compare_msg("hello");
    check("hello_err_count", err_count, 0);

    // Ten 'M' with toggling backpressure; tenth wraps back to key 'P'.
    pulse_start();
    send_str("MMMMMMMMMM", 1'b1, 1'b1);
    drain(10, 1'b1);
    exp_c = {8'd52, 8'd23, 8'd54, 8'd23, 8'd55, 8'd33, 8'd42, 8'd26, 8'd62, 8'd52};
    exp_e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    compare_msg("wrap");

    // Folding and invalid character; 'M' then uses key 'A' (index 3).
    pulse_start();
    send_str("jh5M", 1'b1, 1'b0);
    drain(4, 1'b0);
    exp_c = {8'd56, 8'd43, 8'd00, 8'd23};
    exp_e = {1'b0, 1'b0, 1'b1, 1'b0};
    compare_msg("fold");
    check("fold_err_count", err_count, 1);

    // Reset after three of five beats; pending beats are dropped.
    pulse_start();
    send_str("HEL", 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_cipher", out_cipher, 0);
    check("midrst_out_err", out_err, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_err_count", err_count, 0);
    repeat (3) step();
    out_q.delete();
    pulse_start();
    send_str("HE", 1'b1, 1'b0);
    drain(2, 1'b0);
    exp_c = {8'd72, 8'd26};
    exp_e = {1'b0, 1'b0};
    compare_msg("restart");

    // Gating: in_valid in IDLE is ignored; start in RUN is ignored.
    in_valid = 1'b1;
    in_char  = "H";
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    step();
    check("idle_no_output", out_q.size(), 0);
    pulse_start();
    send_beat("H", 1'b0, 1'b0);
    pulse_start();
    check("run_start_ignored", in_ready, 1);
    send_beat("E", 1'b1, 1'b0);
    drain(2, 1'b0);
    exp_c = {8'd72, 8'd26};
    exp_e = {1'b0, 1'b0};
    compare_msg("gating");

    // Saturation of the 2-bit error counter, then clear on start.
    pulse_start();
    send_str("55555", 1'b1, 1'b0);
    drain(5, 1'b0);
    check("sat_err_count", err_count, 3);
    exp_c = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    exp_e = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    compare_msg("sat");
    pulse_start();
    check("sat_cleared", err_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
